// File: rtl/bcd_to_bin_seq.sv
// Digit-serial packed-BCD to unsigned binary converter (acc = acc*10 + digit, MSD first).
// Valid/ready handshake on both sides; an out-of-range nibble sets err and masks bin_out.
module bcd_to_bin_seq #(
    parameter int unsigned NDIGITS = 3,
    parameter int unsigned BW      = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   bcd_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BW-1:0]          bin_out,
    output logic                   err
);

    localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [4*NDIGITS-1:0]  r_word;
    logic [BW-1:0]         r_acc;
    logic [IdxW-1:0]       r_idx;
    logic                  r_err;

    logic [3:0]            w_digit;
    logic                  w_digit_bad;
    logic [BW-1:0]         w_acc_next;
    logic                  w_accept;
    logic                  w_step;

    // Mux by comparison so a non-power-of-two digit count never indexes past the word.
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (r_idx == IdxW'(i)) begin
                w_digit = r_word[4*i +: 4];
            end
        end
    end

    assign w_digit_bad = (w_digit > 4'd9);

    // Partial sums never exceed the final legal value, so BW bits keep legal results exact;
    // wrap-around only happens with illegal nibbles, whose result is masked anyway.
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BW'(w_digit);

    assign w_accept = in_valid && (r_state == StIdle);
    assign w_step   = (r_state == StConv);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = StConv;
                end
            end
            StConv: begin
                if (r_idx == '0) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_word <= bcd_in;
            r_acc  <= '0;
            r_idx  <= IdxLast;
            r_err  <= 1'b0;
        end else if (w_step) begin
            r_acc <= w_acc_next;
            r_err <= r_err | w_digit_bad;
            if (r_idx != '0) begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    // Results hold in IDLE because acc and err only move on accept or during CONV.
    assign bin_out = r_err ? '0 : r_acc;
    assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed, table-driven bench for bcd_to_bin_seq with hand-sequenced handshake corner cases.
module tb_bcd_to_bin_seq;

    localparam int unsigned NDIGITS = 3;
    localparam int unsigned BW      = 10;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*NDIGITS-1:0] bcd_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [BW-1:0]        bin_out;
    logic                 err;

    int checks;
    int failures;

    bcd_to_bin_seq #(
        .NDIGITS(NDIGITS),
        .BW     (BW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd_in   (bcd_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bin_out  (bin_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One full transaction with out_ready held high; checks latency, result and return to IDLE.
    task automatic convert(input logic [11:0] w, input logic [9:0] eb, input logic ee,
                           input string nm);
        int cnt;
        @(negedge clk);
        out_ready = 1'b1;
        bcd_in    = w;
        in_valid  = 1'b1;
        chk({nm, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, " in_ready after accept"}, 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({nm, " latency edges"}, 32'(cnt), 32'(NDIGITS));
        chk({nm, " bin_out"}, 32'(bin_out), 32'(eb));
        chk({nm, " err"}, 32'(err), 32'(ee));
        @(posedge clk);
        #1;
        chk({nm, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[7];
        logic [11:0] stream[3];
        int          acc_t[$];
        logic [9:0]  res[$];
        int          k;
        int          cnt;
        logic        ahs;

        checks   = 0;
        failures = 0;

        vecs[0] = '{bcd: 12'h154, bin: 10'd154, e: 1'b0};
        vecs[1] = '{bcd: 12'h000, bin: 10'd0,   e: 1'b0};
        vecs[2] = '{bcd: 12'h999, bin: 10'd999, e: 1'b0};
        vecs[3] = '{bcd: 12'h198, bin: 10'd198, e: 1'b0};
        vecs[4] = '{bcd: 12'h1A3, bin: 10'd0,   e: 1'b1};
        vecs[5] = '{bcd: 12'h013, bin: 10'd13,  e: 1'b0};
        vecs[6] = '{bcd: 12'hF00, bin: 10'd0,   e: 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset bin_out", 32'(bin_out), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].bcd, vecs[i].bin, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and no new word may slip in while DONE.
        @(negedge clk);
        out_ready = 1'b0;
        bcd_in    = 12'h777;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("bp latency edges", 32'(cnt), 32'(NDIGITS));
        in_valid = 1'b1;
        bcd_in   = 12'h123;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp bin_out", 32'(bin_out), 32'd777);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp idle holds", 32'(in_ready), 32'd1);

        // Asynchronous reset during the second CONV cycle.
        @(negedge clk);
        bcd_in   = 12'h456;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset bin_out", 32'(bin_out), 32'd0);
        chk("midreset err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(12'h021, 10'd21, 1'b0, "post reset");

        // Back-to-back stream with in_valid held high.
        stream[0] = 12'h001;
        stream[1] = 12'h500;
        stream[2] = 12'h999;
        k = 0;
        @(negedge clk);
        out_ready = 1'b1;
        bcd_in    = stream[0];
        in_valid  = 1'b1;
        for (int c = 0; c < 40 && res.size() < 3; c++) begin
            ahs = in_valid && in_ready;
            if (ahs) acc_t.push_back(c);
            if (out_valid) res.push_back(bin_out);
            @(posedge clk);
            #1;
            if (ahs) begin
                k++;
                if (k < 3) bcd_in = stream[k];
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stream accept count", 32'(acc_t.size()), 32'd3);
        chk("stream result count", 32'(res.size()), 32'd3);
        if (res.size() == 3) begin
            chk("stream res0", 32'(res[0]), 32'd1);
            chk("stream res1", 32'(res[1]), 32'd500);
            chk("stream res2", 32'(res[2]), 32'd999);
        end
        if (acc_t.size() == 3) begin
            chk("stream spacing01", 32'(acc_t[1] - acc_t[0]), 32'd5);
            chk("stream spacing12", 32'(acc_t[2] - acc_t[1]), 32'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
